// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage pipeline CPU.
//   - Opcode and funct encodings recognised by the decoder.
//   - alu_op_e: ALU operation code. ex_stage uses the same encoding.
//   - dec_t:    decoded control fields for one instruction (ID-internal).
//   - id_ex_t:  contents of the ID/EX pipeline register.
//   - decode(): maps opcode/funct onto dec_t; unknown encodings clear 'legal'.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_XLEN   = 32;
  localparam int CPU_NREGS  = 32;
  localparam int CPU_REG_AW = $clog2(CPU_NREGS);
  localparam int CPU_IMM_W  = 16;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef struct packed {
    logic    legal;
    alu_op_e alu_op;
    logic    alu_src;     // 1: second ALU operand is the immediate
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    rt_is_src;   // rt is read as an operand (R-type, sw)
    logic    dest_is_rt;  // destination comes from rt rather than rd
  } dec_t;

  typedef struct packed {
    logic                    valid;
    logic [CPU_XLEN-1:0]     reg1_data;
    logic [CPU_XLEN-1:0]     reg2_data;
    logic [CPU_IMM_W-1:0]    imm;
    logic                    alu_src;
    alu_op_e                 alu_op;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic [CPU_REG_AW-1:0]   dest_reg;
    logic [CPU_REG_AW-1:0]   rs;
    logic [CPU_REG_AW-1:0]   rt;
  } id_ex_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d            = '0;
    d.alu_op     = ALU_ADD;
    d.dest_is_rt = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.legal      = 1'b1;
        d.reg_write  = 1'b1;
        d.rt_is_src  = 1'b1;
        d.dest_is_rt = 1'b0;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_ANDI: begin
        d.legal     = 1'b1;
        d.alu_op    = ALU_AND;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_ORI: begin
        d.legal     = 1'b1;
        d.alu_op    = ALU_OR;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_LW: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_SW: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.rt_is_src = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// NREGS x XLEN general-purpose register file.
//   clk_i, reset_i       clock, synchronous active-high reset (clears all)
//   we_i, waddr_i,
//   wdata_i              write port, written at the rising edge
//   raddr1_i / rdata1_o  read port 1 (combinational)
//   raddr2_i / rdata2_o  read port 2 (combinational)
// Register 0 is hardwired to zero. A read of the address being written in
// the same cycle returns the incoming write data, so WB and ID can overlap
// without a forwarding path of their own.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  always_comb begin
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction-decode stage: decodes the IF/ID instruction, reads operands
// from the register file (written by WB), detects load-use hazards and
// registers the result into the ID/EX register consumed by ex_stage.
//
// Inputs:
//   clk, reset         clock, synchronous active-high reset
//   if_valid, if_instr IF/ID instruction and its valid flag
//   flush              kill the instruction in ID (branch redirect)
//   wb_we/addr/data    register-file write port from WB
// Outputs:
//   stall              combinational; IF and IF/ID hold this cycle
//   illegal            one-cycle pulse: the instruction just issued was unknown
//   ex_valid .. ex_rt  ID/EX register contents
//
// Priority at each edge: reset > flush > load-use hazard > if_valid > idle.
// Every non-issue case loads a bubble: only the control bits are cleared,
// the data fields keep their old value so the EX datapath does not toggle.
// ---------------------------------------------------------------------------
module id_stage
  import cpu_pkg::*;
#(
  parameter  int XLEN  = CPU_XLEN,
  parameter  int NREGS = CPU_NREGS,
  parameter  int IMM_W = CPU_IMM_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic             illegal,
  output logic             ex_valid,
  output logic [XLEN-1:0]  reg1_data,
  output logic [XLEN-1:0]  reg2_data,
  output logic [IMM_W-1:0] imm,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [AW-1:0]    dest_reg,
  output logic [AW-1:0]    ex_rs,
  output logic [AW-1:0]    ex_rt
);

  // Field extraction and decode
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [AW-1:0]   rs;
  logic [AW-1:0]   rt;
  logic [AW-1:0]   rd;
  dec_t            dec;
  logic            unused_shamt;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[25:21];
  assign rt    = if_instr[20:16];
  assign rd    = if_instr[15:11];
  assign funct = if_instr[5:0];
  assign dec   = decode(op, funct);

  // The shift-amount field has no user in this instruction set.
  assign unused_shamt = ^if_instr[10:6];

  // Operand read
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (rs),
    .rdata1_o (rs_val),
    .raddr2_i (rt),
    .rdata2_o (rt_val)
  );

  // Load-use hazard against the instruction now in EX
  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   illegal_q;
  logic   illegal_d;
  logic   hazard;

  // A load into r0 produces nothing to wait for. rt only matters when the
  // instruction actually reads it (R-type, sw).
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.dest_reg != '0) && if_valid &&
                  ((ex_q.dest_reg == rs) || (dec.rt_is_src && (ex_q.dest_reg == rt)));

  // The bubble inserted here clears ex_q.mem_read, so stall self-terminates
  // after one cycle.
  assign stall = hazard && !flush && !reset;

  // Next ID/EX contents
  always_comb begin
    ex_d           = ex_q;
    ex_d.valid     = 1'b0;
    ex_d.mem_read  = 1'b0;
    ex_d.mem_write = 1'b0;
    ex_d.reg_write = 1'b0;
    illegal_d      = 1'b0;
    if (!flush && !hazard && if_valid) begin
      if (dec.legal) begin
        ex_d.valid     = 1'b1;
        ex_d.reg1_data = rs_val;
        ex_d.reg2_data = rt_val;
        ex_d.imm       = if_instr[IMM_W-1:0];
        ex_d.alu_src   = dec.alu_src;
        ex_d.alu_op    = dec.alu_op;
        ex_d.mem_read  = dec.mem_read;
        ex_d.mem_write = dec.mem_write;
        ex_d.reg_write = dec.reg_write;
        ex_d.dest_reg  = dec.dest_is_rt ? rt : rd;
        ex_d.rs        = rs;
        ex_d.rt        = rt;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal   = illegal_q;
  assign ex_valid  = ex_q.valid;
  assign reg1_data = ex_q.reg1_data;
  assign reg2_data = ex_q.reg2_data;
  assign imm       = ex_q.imm;
  assign alu_src   = ex_q.alu_src;
  assign alu_op    = ex_q.alu_op;
  assign mem_read  = ex_q.mem_read;
  assign mem_write = ex_q.mem_write;
  assign reg_write = ex_q.reg_write;
  assign dest_reg  = ex_q.dest_reg;
  assign ex_rs     = ex_q.rs;
  assign ex_rt     = ex_q.rt;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Directed vector table, a reset-during-stall sequence and a randomized run,
// all checked against a behavioural model of the decode stage.
// ---------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        illegal;
  logic        ex_valid;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;
  logic [15:0] imm;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [4:0]  dest_reg;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;

  always #5 clk = ~clk;

  id_stage dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall     (stall),
    .illegal   (illegal),
    .ex_valid  (ex_valid),
    .reg1_data (reg1_data),
    .reg2_data (reg2_data),
    .imm       (imm),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .dest_reg  (dest_reg),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural registers plus the EX-side view.
  logic [31:0] m_regs [32];
  logic        m_valid, m_ill, m_src, m_mr, m_mw, m_rw;
  logic [31:0] m_r1, m_r2;
  logic [15:0] m_imm;
  logic [2:0]  m_op;
  logic [4:0]  m_dest, m_rs, m_rt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int im);
    return {6'(op), 5'(rs), 5'(rt), 16'(im)};
  endfunction

  // Instruction-set semantics: returns 1 for a known instruction.
  function automatic bit mdec(input logic [31:0] ins, output logic [2:0] aop,
                              output bit src, output bit mr, output bit mw,
                              output bit rw, output bit rtsrc, output logic [4:0] dst);
    aop = 3'd0; src = 0; mr = 0; mw = 0; rw = 0; rtsrc = 0; dst = ins[20:16];
    case (ins[31:26])
      6'h00: begin
        rtsrc = 1; rw = 1; dst = ins[15:11];
        case (ins[5:0])
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          6'h2A: aop = 3'd4;
          default: return 0;
        endcase
        return 1;
      end
      6'h08: begin src = 1; rw = 1; return 1; end
      6'h0C: begin aop = 3'd2; src = 1; rw = 1; return 1; end
      6'h0D: begin aop = 3'd3; src = 1; rw = 1; return 1; end
      6'h23: begin src = 1; mr = 1; rw = 1; return 1; end
      6'h2B: begin src = 1; mw = 1; rtsrc = 1; return 1; end
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_ill = 0; m_src = 0; m_mr = 0; m_mw = 0; m_rw = 0;
    m_r1 = 0; m_r2 = 0; m_imm = 0; m_op = 0; m_dest = 0; m_rs = 0; m_rt = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid = v; if_instr = ins; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  // One clock: check stall before the edge, advance the model at the edge,
  // compare every output at the following falling edge.
  task automatic cycle(output logic st);
    logic [2:0]  aop;
    bit          src, mr, mw, rw, rtsrc, legal, hz;
    logic [4:0]  dst, rs, rt;
    logic [31:0] r1, r2;
    #1;
    st = stall;
    rs = if_instr[25:21];
    rt = if_instr[20:16];
    legal = mdec(if_instr, aop, src, mr, mw, rw, rtsrc, dst);
    hz = m_valid && m_mr && (m_dest != 5'd0) && if_valid &&
         ((m_dest == rs) || (rtsrc && (m_dest == rt)));
    check("stall", stall, {31'd0, !reset && !flush && hz});
    r1 = mread(rs);
    r2 = mread(rt);
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_ill = 0;
      if (!flush && !hz && if_valid) begin
        if (legal) begin
          m_valid = 1; m_mr = mr; m_mw = mw; m_rw = rw; m_src = src; m_op = aop;
          m_r1 = r1; m_r2 = r2; m_imm = if_instr[15:0];
          m_dest = dst; m_rs = rs; m_rt = rt;
        end else begin
          m_ill = 1;
        end
      end
    end
    @(negedge clk);
    check("ex_valid",  ex_valid,  m_valid);
    check("illegal",   illegal,   m_ill);
    check("reg_write", reg_write, m_rw);
    check("mem_read",  mem_read,  m_mr);
    check("mem_write", mem_write, m_mw);
    check("reg1_data", reg1_data, m_r1);
    check("reg2_data", reg2_data, m_r2);
    check("imm",       imm,       m_imm);
    check("alu_src",   alu_src,   m_src);
    check("alu_op",    alu_op,    m_op);
    check("dest_reg",  dest_reg,  m_dest);
    check("ex_rs",     ex_rs,     m_rs);
    check("ex_rt",     ex_rt,     m_rt);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        fl;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_stall;
    logic        e_valid;
    logic        e_ill;
    logic        chk_d;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [2:0]  e_op;
    logic [4:0]  e_dest;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic fl,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic est, input logic evld, input logic eill,
                              input logic chk, input logic [31:0] er1, input logic [31:0] er2,
                              input logic [2:0] eop, input logic [4:0] edst);
    vec_t t;
    t.v = v; t.ins = ins; t.fl = fl; t.we = we; t.wa = wa; t.wd = wd;
    t.e_stall = est; t.e_valid = evld; t.e_ill = eill; t.chk_d = chk;
    t.e_r1 = er1; t.e_r2 = er2; t.e_op = eop; t.e_dest = edst;
    return t;
  endfunction

  vec_t        tbl [25];
  logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0]  bad_op [4] = '{6'h3F, 6'h01, 6'h04, 6'h2C};

  initial begin
    logic        st;
    logic [31:0] ins;

    model_clear();
    //               v  instr                    fl we wa  wd            st vl il chk r1  r2 op dest
    tbl[0]  = mk(0, 32'd0,                   0, 1, 1,  32'd10,       0, 0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, itype('h08,1,2,8),       0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 0, 2);
    tbl[2]  = mk(1, rtype(1,4,3,'h22),       0, 1, 4,  32'd5,        0, 1, 0, 1, 10, 5, 1, 3);
    tbl[3]  = mk(1, itype('h23,1,5,0),       0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 0, 5);
    tbl[4]  = mk(1, rtype(5,1,6,'h25),       0, 0, 0,  32'd0,        1, 0, 0, 0, 0,  0, 0, 0);
    tbl[5]  = mk(1, rtype(5,1,6,'h25),       0, 0, 0,  32'd0,        0, 1, 0, 1, 0, 10, 3, 6);
    tbl[6]  = mk(1, itype('h23,1,5,4),       0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 0, 5);
    tbl[7]  = mk(1, itype('h0C,5,8,'hF),     1, 0, 0,  32'd0,        0, 0, 0, 0, 0,  0, 0, 0);
    tbl[8]  = mk(1, itype('h0C,5,8,'hF),     0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 2, 8);
    tbl[9]  = mk(1, itype('h0C,5,8,'hF),     1, 0, 0,  32'd0,        0, 0, 0, 0, 0,  0, 0, 0);
    tbl[10] = mk(1, rtype(0,0,7,'h20),       0, 1, 0,  32'hFFFFFFFF, 0, 1, 0, 1, 0,  0, 0, 7);
    tbl[11] = mk(1, 32'hFC000000,            0, 0, 0,  32'd0,        0, 0, 1, 0, 0,  0, 0, 0);
    tbl[12] = mk(0, 32'd0,                   0, 0, 0,  32'd0,        0, 0, 0, 0, 0,  0, 0, 0);
    tbl[13] = mk(1, rtype(1,1,9,'h3F),       0, 0, 0,  32'd0,        0, 0, 1, 0, 0,  0, 0, 0);
    tbl[14] = mk(1, rtype(1,3,9,'h2A),       0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 4, 9);
    tbl[15] = mk(1, itype('h23,0,10,0),      0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 10);
    tbl[16] = mk(1, itype('h2B,1,10,4),      0, 0, 0,  32'd0,        1, 0, 0, 0, 0,  0, 0, 0);
    tbl[17] = mk(1, itype('h2B,1,10,4),      0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 0, 10);
    tbl[18] = mk(1, itype('h23,0,11,0),      0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 11);
    tbl[19] = mk(1, itype('h08,0,11,1),      0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 11);
    tbl[20] = mk(1, itype('h23,0,0,0),       0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 0);
    tbl[21] = mk(1, rtype(0,0,12,'h20),      0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 12);
    tbl[22] = mk(1, itype('h23,0,5,0),       0, 0, 0,  32'd0,        0, 1, 0, 1, 0,  0, 0, 5);
    tbl[23] = mk(0, rtype(5,1,6,'h25),       0, 0, 0,  32'd0,        0, 0, 0, 0, 0,  0, 0, 0);
    tbl[24] = mk(1, itype('h0D,1,13,'hFF),   0, 0, 0,  32'd0,        0, 1, 0, 1, 10, 0, 3, 13);

    // Reset for two cycles, with a load presented to prove reset wins.
    reset = 1;
    drive(1, itype('h23, 1, 2, 0), 0, 1, 3, 32'h1234);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle(st);
      check("rst_stall", st, 0);
      check("rst_ex_valid", ex_valid, 0);
      check("rst_reg1", reg1_data, 0);
      check("rst_dest", dest_reg, 0);
    end
    reset = 0;

    // Every register reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      drive(1, rtype(i, 31 - i, 1, 'h20), 0, 0, 0, 0);
      cycle(st);
      check($sformatf("zero_r%0d", i), reg1_data, 0);
    end

    // Directed vectors.
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].ins, tbl[i].fl, tbl[i].we, tbl[i].wa, tbl[i].wd);
      cycle(st);
      check($sformatf("tbl%0d_stall", i), st, tbl[i].e_stall);
      check($sformatf("tbl%0d_valid", i), ex_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_illegal", i), illegal, tbl[i].e_ill);
      if (tbl[i].chk_d) begin
        check($sformatf("tbl%0d_reg1", i), reg1_data, tbl[i].e_r1);
        check($sformatf("tbl%0d_reg2", i), reg2_data, tbl[i].e_r2);
        check($sformatf("tbl%0d_alu_op", i), alu_op, tbl[i].e_op);
        check($sformatf("tbl%0d_dest", i), dest_reg, tbl[i].e_dest);
      end
    end

    // Reset arriving while a load-use stall is active.
    drive(1, itype('h23, 0, 5, 0), 0, 0, 0, 0);
    cycle(st);
    drive(1, rtype(5, 1, 6, 'h25), 0, 0, 0, 0);
    #1 check("mid_stall_before_reset", stall, 1);
    reset = 1;
    cycle(st);
    check("mid_stall_during_reset", st, 0);
    check("mid_stall_ex_valid", ex_valid, 0);
    reset = 0;
    cycle(st);
    check("after_reset_stall", st, 0);
    check("after_reset_valid", ex_valid, 1);
    check("after_reset_alu_op", alu_op, 3);

    // Randomized run; the instruction is held while stall is seen, as IF would.
    st = 0;
    ins = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!st) begin
        case ($urandom_range(0, 8))
          0: ins = {rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          fn_tab[$urandom_range(0, 4)])} | {21'd0, 5'($urandom), 6'd0};
          1: ins = itype('h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          2: ins = itype('h0C, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          3: ins = itype('h0D, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          4, 5: ins = itype('h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          6: ins = itype('h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          7: ins = itype(bad_op[$urandom_range(0, 3)], $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom);
          default: ins = rtype($urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? 'h21 : 'h00);
        endcase
      end
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      cycle(st);
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
